// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: default widths, bubble constants and the M->W entry layout.
package mips_pkg;

   localparam int unsigned MIPS_DATA_W   = 32;
   localparam int unsigned MIPS_AUX_W    = 8;
   localparam logic [31:0] MIPS_PC_RESET = 32'h0000_3000;
   localparam logic [31:0] MIPS_NOP_IR   = 32'h0000_0000;

   // Entry at default widths; parametrised instances pack the same field order into a flat word.
   typedef struct packed {
      logic [31:0] ir;
      logic [31:0] pc;
      logic [31:0] ao;
      logic [31:0] dm;
      logic        br;
      logic [7:0]  aux;
   } mw_entry_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry valid/ready buffer (head + skid) with registered in_ready and a flush.
module pipe_skid_buf #(
   parameter int unsigned W = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         flush_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] in_data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] out_data_o
);

   logic         head_vld_q, head_vld_d;
   logic         skid_vld_q, skid_vld_d;
   logic         rdy_q, rdy_d;
   logic [W-1:0] head_q, head_d;
   logic [W-1:0] skid_q, skid_d;
   logic         accept;
   logic         pop;

   assign accept = in_valid_i & rdy_q;
   assign pop    = head_vld_q & out_ready_i;

   always_comb begin
      head_vld_d = head_vld_q;
      skid_vld_d = skid_vld_q;
      head_d     = head_q;
      skid_d     = skid_q;
      if (flush_i) begin
         head_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end else if (!head_vld_q) begin
         if (accept) begin
            head_vld_d = 1'b1;
            head_d     = in_data_i;
         end
      end else if (pop) begin
         // rdy_q is low whenever the skid is occupied, so accept and a skid refill never coincide.
         if (skid_vld_q) begin
            head_d     = skid_q;
            skid_vld_d = 1'b0;
         end else if (accept) begin
            head_d     = in_data_i;
         end else begin
            head_vld_d = 1'b0;
         end
      end else if (accept) begin
         skid_vld_d = 1'b1;
         skid_d     = in_data_i;
      end
      rdy_d = ~skid_vld_d;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
         rdy_q      <= 1'b1;
      end else begin
         head_vld_q <= head_vld_d;
         skid_vld_q <= skid_vld_d;
         rdy_q      <= rdy_d;
      end
   end

   // Payload is qualified by the valid flags, so it needs no reset.
   always_ff @(posedge clk_i) begin
      head_q <= head_d;
      skid_q <= skid_d;
   end

   assign in_ready_o  = rdy_q;
   assign out_valid_o = head_vld_q;
   assign out_data_o  = head_q;

endmodule

// File: rtl/mw_pipe_stage.sv
// M->W inter-stage register: skid-buffered valid/ready handshake, flush bubble, pc+4/pc+8, stall counter.
module mw_pipe_stage
   import mips_pkg::*;
#(
   parameter int unsigned         DATA_W   = MIPS_DATA_W,
   parameter int unsigned         AUX_W    = MIPS_AUX_W,
   parameter logic [DATA_W-1:0]   PC_RESET = DATA_W'(MIPS_PC_RESET),
   parameter logic [DATA_W-1:0]   NOP_IR   = DATA_W'(MIPS_NOP_IR),
   parameter int unsigned         CNT_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_ir,
   input  logic [DATA_W-1:0] in_pc,
   input  logic [DATA_W-1:0] in_ao,
   input  logic [DATA_W-1:0] in_do,
   input  logic              in_br,
   input  logic [AUX_W-1:0]  in_aux,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_ir,
   output logic [DATA_W-1:0] out_ao,
   output logic [DATA_W-1:0] out_do,
   output logic [DATA_W-1:0] out_pc4,
   output logic [DATA_W-1:0] out_pc8,
   output logic              out_br,
   output logic [AUX_W-1:0]  out_aux,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int unsigned       PW      = 4 * DATA_W + 1 + AUX_W;
   localparam logic [CNT_W-1:0]  CNT_MAX = '1;

   function automatic logic [DATA_W-1:0] pc_add(input logic [DATA_W-1:0] pc, input int unsigned k);
      return pc + DATA_W'(k);
   endfunction

   logic [PW-1:0]     in_pl, head_pl;
   logic              head_vld;
   logic [DATA_W-1:0] h_ir, h_pc, h_ao, h_do, pc_sel;
   logic              h_br;
   logic [AUX_W-1:0]  h_aux;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   assign in_pl = {in_ir, in_pc, in_ao, in_do, in_br, in_aux};

   pipe_skid_buf #(
      .W (PW)
   ) u_buf (
      .clk_i       (clk),
      .rst_ni      (reset),
      .flush_i     (flush),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_data_i   (in_pl),
      .out_valid_o (head_vld),
      .out_ready_i (out_ready),
      .out_data_o  (head_pl)
   );

   assign {h_ir, h_pc, h_ao, h_do, h_br, h_aux} = head_pl;

   // An empty head shows the bubble rather than whatever payload was last held.
   assign out_valid = head_vld;
   assign out_ir    = head_vld ? h_ir  : NOP_IR;
   assign pc_sel    = head_vld ? h_pc  : PC_RESET;
   assign out_ao    = head_vld ? h_ao  : '0;
   assign out_do    = head_vld ? h_do  : '0;
   assign out_br    = head_vld ? h_br  : 1'b0;
   assign out_aux   = head_vld ? h_aux : '0;
   assign out_pc4   = pc_add(pc_sel, 4);
   assign out_pc8   = pc_add(pc_sel, 8);

   always_comb begin
      cnt_d = cnt_q;
      if (head_vld && !out_ready && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_mw_pipe_stage.sv
// Bench for mw_pipe_stage: vector table, directed corner sequences and random traffic vs. a queue model.
module tb_mw_pipe_stage;
   import mips_pkg::*;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset, flush, in_valid, in_ready, out_valid, out_ready, in_br, out_br;
   logic [31:0]   in_ir, in_pc, in_ao, in_do, out_ir, out_ao, out_do, out_pc4, out_pc8;
   logic [7:0]    in_aux, out_aux;
   logic [CW-1:0] stall_cnt;

   always #5 clk = ~clk;

   mw_pipe_stage #(
      .DATA_W   (32),
      .AUX_W    (8),
      .PC_RESET (32'h0000_3000),
      .NOP_IR   (32'h0000_0000),
      .CNT_W    (CW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ir     (in_ir),
      .in_pc     (in_pc),
      .in_ao     (in_ao),
      .in_do     (in_do),
      .in_br     (in_br),
      .in_aux    (in_aux),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ir    (out_ir),
      .out_ao    (out_ao),
      .out_do    (out_do),
      .out_pc4   (out_pc4),
      .out_pc8   (out_pc8),
      .out_br    (out_br),
      .out_aux   (out_aux),
      .stall_cnt (stall_cnt)
   );

   // Reference: the stage is a FIFO of capacity two; in_ready means "at most one entry held".
   mw_entry_t mq[$];
   bit        m_rdy;
   int        m_cnt;
   int        n_vec = 0;
   int        n_bad = 0;

   function automatic mw_entry_t mk_ent(input logic [31:0] ir, input logic [31:0] pc);
      mw_entry_t e;
      e.ir  = ir;
      e.pc  = pc;
      e.ao  = ir ^ 32'h5A5A_A5A5;
      e.dm  = ~ir;
      e.br  = ir[0];
      e.aux = ir[7:0] ^ 8'h3C;
      return e;
   endfunction

   task automatic model_clear();
      mq.delete();
      m_rdy = 1'b1;
      m_cnt = 0;
   endtask

   task automatic model_edge(input bit fl, input bit iv, input bit ordy, input mw_entry_t e);
      bit acc;
      acc = iv && m_rdy;
      if (mq.size() > 0 && !ordy && m_cnt < (1 << CW) - 1) m_cnt++;
      if (fl) begin
         mq.delete();
      end else begin
         if (mq.size() > 0 && ordy) void'(mq.pop_front());
         if (acc) mq.push_back(e);
      end
      m_rdy = (mq.size() < 2);
   endtask

   task automatic cycle(input bit fl, input bit iv, input bit ordy, input mw_entry_t e);
      flush     = fl;
      in_valid  = iv;
      out_ready = ordy;
      in_ir     = e.ir;
      in_pc     = e.pc;
      in_ao     = e.ao;
      in_do     = e.dm;
      in_br     = e.br;
      in_aux    = e.aux;
      model_edge(fl, iv, ordy, e);
      @(posedge clk);
      #1;
   endtask

   task automatic check_model(input string nm);
      bit          e_v;
      logic [31:0] e_ir, e_pc, e_ao, e_do;
      logic        e_br;
      logic [7:0]  e_aux;
      if (mq.size() > 0) begin
         e_v = 1'b1; e_ir = mq[0].ir; e_pc = mq[0].pc; e_ao = mq[0].ao;
         e_do = mq[0].dm; e_br = mq[0].br; e_aux = mq[0].aux;
      end else begin
         e_v = 1'b0; e_ir = 32'h0; e_pc = 32'h0000_3000; e_ao = 32'h0;
         e_do = 32'h0; e_br = 1'b0; e_aux = 8'h0;
      end
      n_vec++;
      if (out_valid !== e_v || in_ready !== m_rdy || out_ir !== e_ir ||
          out_pc4 !== e_pc + 32'd4 || out_pc8 !== e_pc + 32'd8 || out_ao !== e_ao ||
          out_do !== e_do || out_br !== e_br || out_aux !== e_aux || stall_cnt !== CW'(m_cnt)) begin
         n_bad++;
         $display("FAIL %s: got v=%0b rdy=%0b ir=%h pc4=%h pc8=%h ao=%h do=%h br=%0b aux=%h cnt=%0d; want v=%0b rdy=%0b ir=%h pc4=%h pc8=%h ao=%h do=%h br=%0b aux=%h cnt=%0d",
                  nm, out_valid, in_ready, out_ir, out_pc4, out_pc8, out_ao, out_do, out_br, out_aux, stall_cnt,
                  e_v, m_rdy, e_ir, e_pc + 32'd4, e_pc + 32'd8, e_ao, e_do, e_br, e_aux, m_cnt);
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, got, exp);
      end
   endtask

   task automatic check_reset_vals(input string nm);
      chk({nm, "_valid"}, {31'd0, out_valid}, 32'd0);
      chk({nm, "_ready"}, {31'd0, in_ready}, 32'd1);
      chk({nm, "_ir"}, out_ir, 32'h0);
      chk({nm, "_pc4"}, out_pc4, 32'h0000_3004);
      chk({nm, "_pc8"}, out_pc8, 32'h0000_3008);
      chk({nm, "_cnt"}, 32'(stall_cnt), 32'd0);
   endtask

   // Reset asserted asynchronously mid-cycle; released away from the clock edge with idle inputs.
   task automatic do_reset(input string nm);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      #2 reset = 1'b0;
      model_clear();
      #1 check_reset_vals(nm);
      @(negedge clk) reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit          fl, iv, ordy;
      logic [31:0] ir, pc;
      bit          e_v, e_r;
      logic [31:0] e_ir, e_pc4, e_pc8;
   } vec_t;

   vec_t tbl[14];

   function automatic vec_t mk_vec(input bit fl, input bit iv, input bit ordy,
                                   input logic [31:0] ir, input logic [31:0] pc,
                                   input bit e_v, input bit e_r, input logic [31:0] e_ir,
                                   input logic [31:0] e_pc4, input logic [31:0] e_pc8);
      vec_t v;
      v.fl = fl; v.iv = iv; v.ordy = ordy; v.ir = ir; v.pc = pc;
      v.e_v = e_v; v.e_r = e_r; v.e_ir = e_ir; v.e_pc4 = e_pc4; v.e_pc8 = e_pc8;
      return v;
   endfunction

   initial begin
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_ir = '0; in_pc = '0; in_ao = '0; in_do = '0; in_br = 1'b0; in_aux = '0;
      model_clear();

      tbl[0]  = mk_vec(0, 1, 0, 32'h0A0A_0001, 32'h0000_3010, 1, 1, 32'h0A0A_0001, 32'h0000_3014, 32'h0000_3018);
      tbl[1]  = mk_vec(0, 1, 0, 32'h0B0B_0002, 32'h0000_3014, 1, 0, 32'h0A0A_0001, 32'h0000_3014, 32'h0000_3018);
      tbl[2]  = mk_vec(0, 1, 0, 32'h0C0C_0003, 32'h0000_3018, 1, 0, 32'h0A0A_0001, 32'h0000_3014, 32'h0000_3018);
      tbl[3]  = mk_vec(0, 1, 1, 32'h0C0C_0003, 32'h0000_3018, 1, 1, 32'h0B0B_0002, 32'h0000_3018, 32'h0000_301C);
      tbl[4]  = mk_vec(0, 1, 1, 32'h0C0C_0003, 32'h0000_3018, 1, 1, 32'h0C0C_0003, 32'h0000_301C, 32'h0000_3020);
      tbl[5]  = mk_vec(0, 0, 1, 32'h0000_0000, 32'h0000_0000, 0, 1, 32'h0000_0000, 32'h0000_3004, 32'h0000_3008);
      tbl[6]  = mk_vec(0, 1, 0, 32'h0D0D_0004, 32'h0000_3020, 1, 1, 32'h0D0D_0004, 32'h0000_3024, 32'h0000_3028);
      tbl[7]  = mk_vec(0, 1, 0, 32'h0E0E_0005, 32'h0000_3024, 1, 0, 32'h0D0D_0004, 32'h0000_3024, 32'h0000_3028);
      tbl[8]  = mk_vec(1, 1, 0, 32'h0F0F_0006, 32'h0000_3028, 0, 1, 32'h0000_0000, 32'h0000_3004, 32'h0000_3008);
      tbl[9]  = mk_vec(0, 0, 1, 32'h0000_0000, 32'h0000_0000, 0, 1, 32'h0000_0000, 32'h0000_3004, 32'h0000_3008);
      tbl[10] = mk_vec(0, 1, 1, 32'h1111_0007, 32'hFFFF_FFFC, 1, 1, 32'h1111_0007, 32'h0000_0000, 32'h0000_0004);
      tbl[11] = mk_vec(0, 1, 1, 32'h1212_0008, 32'h0000_3030, 1, 1, 32'h1212_0008, 32'h0000_3034, 32'h0000_3038);
      tbl[12] = mk_vec(1, 1, 1, 32'h1313_0009, 32'h0000_3034, 0, 1, 32'h0000_0000, 32'h0000_3004, 32'h0000_3008);
      tbl[13] = mk_vec(0, 0, 1, 32'h0000_0000, 32'h0000_0000, 0, 1, 32'h0000_0000, 32'h0000_3004, 32'h0000_3008);

      #12;
      check_reset_vals("por");
      @(negedge clk) reset = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 14; i++) begin
         cycle(tbl[i].fl, tbl[i].iv, tbl[i].ordy, mk_ent(tbl[i].ir, tbl[i].pc));
         n_vec++;
         if (out_valid !== tbl[i].e_v || in_ready !== tbl[i].e_r || out_ir !== tbl[i].e_ir ||
             out_pc4 !== tbl[i].e_pc4 || out_pc8 !== tbl[i].e_pc8) begin
            n_bad++;
            $display("FAIL tbl[%0d]: got v=%0b rdy=%0b ir=%h pc4=%h pc8=%h; want v=%0b rdy=%0b ir=%h pc4=%h pc8=%h",
                     i, out_valid, in_ready, out_ir, out_pc4, out_pc8,
                     tbl[i].e_v, tbl[i].e_r, tbl[i].e_ir, tbl[i].e_pc4, tbl[i].e_pc8);
         end
         check_model($sformatf("tbl_model[%0d]", i));
      end

      // Full-rate stream: each word on the outputs one cycle after it is offered.
      for (int i = 0; i < 8; i++) begin
         cycle(0, 1, 1, mk_ent(32'h2408_0001 + 32'(i), 32'h0000_3000 + 32'(4 * i)));
         chk($sformatf("stream_ir[%0d]", i), out_ir, 32'h2408_0001 + 32'(i));
         chk($sformatf("stream_rdy[%0d]", i), {31'd0, in_ready}, 32'd1);
         check_model($sformatf("stream_model[%0d]", i));
      end

      cycle(0, 1, 0, mk_ent(32'h2408_0009, 32'h0000_3020));
      cycle(0, 1, 0, mk_ent(32'h2408_000A, 32'h0000_3024));
      check_model("pre_reset_full");
      do_reset("midrst");

      // Stall counter saturation; flush leaves it alone, only reset clears it.
      cycle(0, 1, 0, mk_ent(32'hABCD_0001, 32'h0000_4000));
      for (int i = 0; i < 20; i++) cycle(0, 0, 0, mk_ent(32'h0, 32'h0));
      chk("stall_sat", 32'(stall_cnt), 32'd15);
      check_model("stall_model");
      cycle(1, 0, 0, mk_ent(32'h0, 32'h0));
      chk("stall_after_flush", 32'(stall_cnt), 32'd15);
      check_model("flush_model");
      cycle(0, 0, 1, mk_ent(32'h0, 32'h0));
      chk("stall_hold", 32'(stall_cnt), 32'd15);
      do_reset("cnt_rst");

      for (int i = 0; i < 400; i++) begin
         logic [31:0] pc;
         pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
         cycle($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
               mk_ent($urandom, pc));
         check_model($sformatf("rand[%0d]", i));
         if (i == 200) do_reset("rand_rst");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
